// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - frame configuration loader driving FrameData and FrameStrobe
// Optional FRAME_CHECK_EN: each frame ends with an XOR check word that gates the strobe.
module frame_config_loader #(
  parameter int NumberOfRows    = 8,
  parameter int NumberOfCols    = 8,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                                      CLK,
  input  logic                                      reset,
  input  logic [31:0]                               cfg_data,
  input  logic                                      cfg_valid,
  output logic                                      cfg_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0]   FrameStrobe,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      cfg_error
);

  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;
  localparam int SW = NumberOfCols * MaxFramesPerCol;
  localparam int IW = (SW > 1) ? $clog2(SW) : 1;
  localparam int CW = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;
  localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef FRAME_CHECK_EN
    S_CHECK,
`endif
    S_STROBE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                                    r_started;
  logic [CW-1:0]                           r_col;
  logic [FW-1:0]                           r_frame;
  logic [RW-1:0]                           r_row;
  logic [NumberOfRows*FrameBitsPerRow-1:0] r_frame_data;
  logic [SW-1:0]                           r_strobe;
  logic                                    r_done;
  logic                                    r_err;
`ifdef FRAME_CHECK_EN
  logic [31:0]                             r_xor;
  logic                                    w_check_ok;
`endif

  logic          w_xfer;
  logic          w_addr_ok;
  logic          w_last;
  logic [IW-1:0] w_idx;

  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_addr_ok = ({24'b0, cfg_data[31:24]} < 32'(NumberOfCols)) &&
                     ({24'b0, cfg_data[23:16]} < 32'(MaxFramesPerCol));
  assign w_last    = (r_row == RW'(NumberOfRows - 1));
  assign w_idx     = IW'(r_col) * IW'(MaxFramesPerCol) + IW'(r_frame);
`ifdef FRAME_CHECK_EN
  assign w_check_ok = (cfg_data == r_xor);
`endif

  always_ff @(posedge CLK) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer && cfg_data == SYNC) w_next = S_ADDR;
      S_ADDR: begin
        if (w_xfer) begin
          if (cfg_data == DESYNC || !w_addr_ok) w_next = S_IDLE;
          else                                  w_next = S_DATA;
        end
      end
      S_DATA: begin
`ifdef FRAME_CHECK_EN
        if (w_xfer && w_last) w_next = S_CHECK;
`else
        if (w_xfer && w_last) w_next = S_STROBE;
`endif
      end
`ifdef FRAME_CHECK_EN
      S_CHECK: if (w_xfer) w_next = w_check_ok ? S_STROBE : S_ADDR;
`endif
      S_STROBE: w_next = S_ADDR;
      default:  w_next = S_IDLE;
    endcase
  end

  // r_started keeps cfg_ready low while reset is held even though the state is IDLE
  always_comb begin
    busy      = (r_state != S_IDLE);
    cfg_ready = r_started && (r_state != S_STROBE);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_started    <= 1'b0;
      r_col        <= '0;
      r_frame      <= '0;
      r_row        <= '0;
      r_frame_data <= '0;
      r_strobe     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef FRAME_CHECK_EN
      r_xor        <= '0;
`endif
    end else begin
      r_started <= 1'b1;
      r_strobe  <= '0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: if (w_xfer && cfg_data == SYNC) r_err <= 1'b0;
        S_ADDR: begin
          if (w_xfer && cfg_data != DESYNC) begin
            if (!w_addr_ok) begin
              r_err <= 1'b1;
            end else begin
              r_col   <= cfg_data[24 +: CW];
              r_frame <= cfg_data[16 +: FW];
              r_row   <= '0;
`ifdef FRAME_CHECK_EN
              r_xor   <= '0;
`endif
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_frame_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
            r_row <= r_row + RW'(1);
`ifdef FRAME_CHECK_EN
            r_xor <= r_xor ^ cfg_data;
`else
            if (w_last) begin
              r_strobe <= SW'(1) << w_idx;
              r_done   <= 1'b1;
            end
`endif
          end
        end
`ifdef FRAME_CHECK_EN
        S_CHECK: begin
          if (w_xfer) begin
            if (w_check_ok) begin
              r_strobe <= SW'(1) << w_idx;
              r_done   <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign FrameData   = r_frame_data;
  assign FrameStrobe = r_strobe;
  assign frame_done  = r_done;
  assign cfg_error   = r_err;

endmodule

// File: tb/tb_frame_config_loader.sv
// tb/tb_frame_config_loader.sv - scoreboard bench for frame_config_loader
// Optional FRAME_CHECK_EN adds check words and a check-mismatch scenario.
module tb_frame_config_loader;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int MF   = 20;
  localparam int DW   = ROWS * 32;
  localparam int SW   = COLS * MF;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          busy;
  logic          frame_done;
  logic          cfg_error;

  frame_config_loader #(
    .NumberOfRows(ROWS), .NumberOfCols(COLS), .FrameBitsPerRow(32), .MaxFramesPerCol(MF)
  ) dut (
    .CLK(CLK), .reset(reset), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [SW-1:0] strobe;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_rdy = 1'b0;
  bit   gaps_on = 1'b1;

  // reference model: protocol phase, current frame address, data words, error flag, bus image
  int            ph = 0;
  int            k = 0;
  logic [31:0]   md[ROWS];
  logic [31:0]   td[ROWS];
  int            mcol = 0;
  int            mfr = 0;
  bit            merr = 1'b0;
  logic [DW-1:0] mfd = '0;
  logic [SW-1:0] exp43;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  function automatic void push_exp();
    exp_t e;
    e.strobe = '0;
    e.strobe[mcol*MF + mfr] = 1'b1;
    e.data = mfd;
    e.cyc = cyc;
    sb.push_back(e);
  endfunction

  function automatic void model_accept(logic [31:0] w);
    logic [31:0] x;
    case (ph)
      0: if (w == SYNC) begin ph = 1; merr = 1'b0; end
      1: begin
        if (w == DESYNC) ph = 0;
        else if (int'(w[31:24]) >= COLS || int'(w[23:16]) >= MF) begin merr = 1'b1; ph = 0; end
        else begin mcol = int'(w[31:24]); mfr = int'(w[23:16]); k = 0; ph = 2; end
      end
      2: begin
        md[k] = w;
        mfd[k*32 +: 32] = w;
        k++;
        if (k == ROWS) begin
`ifdef FRAME_CHECK_EN
          ph = 3;
`else
          push_exp();
          ph = 1;
`endif
        end
      end
      3: begin
        x = '0;
        for (int i = 0; i < ROWS; i++) x = x ^ md[i];
        if (w == x) push_exp();
        else merr = 1'b1;
        ph = 1;
      end
      default: ph = 0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (!reset) begin
      if (frame_done || FrameStrobe != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got %0h exp none", FrameStrobe);
        end else begin
          me = sb.pop_front();
          chk("strobe_bits", DW'(FrameStrobe), DW'(me.strobe));
          chk("frame_done", DW'(frame_done), DW'(1));
          chk("strobe_data", FrameData, me.data);
          chk("strobe_cycle", DW'(cyc), DW'(me.cyc));
        end
      end
      if (mon_rdy) chk("ready_vs_strobe", DW'(cfg_ready), DW'(!frame_done));
    end
  end

  task automatic send_word(logic [31:0] w);
    int n;
    bit rd;
    n = 0;
    rd = 1'b0;
    if (gaps_on && $urandom_range(0, 2) == 0) begin
      cfg_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
    end
    cfg_data = w;
    cfg_valid = 1'b1;
    while (!rd && n < 40) begin
      @(negedge CLK);
      rd = cfg_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    cfg_valid = 1'b0;
    if (!rd) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout got no_ready exp ready");
    end else begin
      model_accept(w);
      chk("busy", DW'(busy), DW'(ph != 0));
      chk("cfg_error", DW'(cfg_error), DW'(merr));
      chk("frame_data", FrameData, mfd);
    end
  endtask

  task automatic send_frame(int col, int fr, bit bad);
    logic [31:0] x;
    x = '0;
    send_word({col[7:0], fr[7:0], 16'($urandom)});
    for (int i = 0; i < ROWS; i++) begin
      send_word(td[i]);
      x = x ^ td[i];
    end
`ifdef FRAME_CHECK_EN
    send_word(bad ? 32'h0 : x);
`else
    if (bad) x = '0;
`endif
  endtask

  task automatic rand_td();
    for (int i = 0; i < ROWS; i++) td[i] = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_framedata", FrameData, '0);
    chk("rst_strobe", DW'(FrameStrobe), '0);
    chk("rst_done", DW'(frame_done), '0);
    chk("rst_error", DW'(cfg_error), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_ready", DW'(cfg_ready), '0);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("ready_after_reset", DW'(cfg_ready), DW'(1));
    mon_rdy = 1'b1;

    send_word(32'h1234_5678);
    send_word(DESYNC);

    for (int i = 0; i < ROWS; i++) td[i] = 32'(i + 1);
    send_word(SYNC);
    send_frame(2, 3, 1'b0);
    exp43 = '0;
    exp43[43] = 1'b1;
    chk("strobe_bit43", DW'(FrameStrobe), DW'(exp43));
    for (int i = 0; i < ROWS; i++) chk("row_value", DW'(FrameData[i*32 +: 32]), DW'(i + 1));

    send_word(DESYNC);
    send_word(SYNC);
    send_word(32'h0800_0000);
    chk("bad_col_error", DW'(cfg_error), DW'(1));
    chk("bad_col_idle", DW'(busy), DW'(0));
    send_word(SYNC);
    chk("sync_clears_error", DW'(cfg_error), DW'(0));

    rand_td();
    send_frame(0, 0, 1'b0);
    rand_td();
    send_frame(7, 19, 1'b0);

`ifdef FRAME_CHECK_EN
    for (int i = 0; i < ROWS; i++) td[i] = 32'(i + 1);
    send_frame(1, 1, 1'b1);
    chk("check_bad_error", DW'(cfg_error), DW'(1));
    chk("check_bad_nostrobe", DW'(FrameStrobe), '0);
    rand_td();
    send_frame(1, 2, 1'b0);
`endif

    repeat (16) begin
      int r;
      if (ph == 0) send_word(SYNC);
      rand_td();
      r = $urandom_range(0, 7);
      if (r == 0)      send_frame($urandom_range(COLS, 255), $urandom_range(0, MF - 1), 1'b0);
      else if (r == 1) send_frame($urandom_range(0, COLS - 1), $urandom_range(MF, 255), 1'b0);
      else             send_frame($urandom_range(0, COLS - 1), $urandom_range(0, MF - 1),
                                  $urandom_range(0, 4) == 0);
    end

    gaps_on = 1'b0;
    if (ph == 0) send_word(SYNC);
    send_word(32'h0304_0000);
    for (int i = 0; i < 4; i++) send_word($urandom);
    mon_rdy = 1'b0;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    ph = 0;
    merr = 1'b0;
    mfd = '0;
    chk("midreset_framedata", FrameData, '0);
    chk("midreset_strobe", DW'(FrameStrobe), '0);
    chk("midreset_busy", DW'(busy), '0);
    chk("midreset_ready", DW'(cfg_ready), '0);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("ready_after_release", DW'(cfg_ready), DW'(1));
    mon_rdy = 1'b1;

    gaps_on = 1'b1;
    send_word(SYNC);
    rand_td();
    send_frame(5, 10, 1'b0);

    repeat (5) begin @(posedge CLK); #1; end
    chk("scoreboard_empty", DW'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
